// File: rtl/fbuf_loader.sv
// fbuf_loader: fetches one output-channel group of weights from DRAM into the filter buffer
// Optional XOR checksum of loaded words is enabled by defining FBUF_LOADER_CHECKSUM_EN.
module fbuf_loader #(
  parameter int W_CHANNEL = 5,
  parameter int W_DATA    = 32,
  parameter int W_ADDR    = 12,
  parameter int K_WORDS   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_fb_load_req,
  input  logic                 i_csync_run,
  input  logic [W_CHANNEL-1:0] i_q_channel,
  input  logic [W_CHANNEL-1:0] i_chn_out,
  output logic                 o_rd_req,
  output logic [W_ADDR-1:0]    o_rd_base,
  output logic [W_ADDR-1:0]    o_rd_len,
  input  logic                 s_valid,
  input  logic [W_DATA-1:0]    s_data,
  output logic                 s_ready,
  output logic                 o_wr_en,
  output logic [W_ADDR-1:0]    o_wr_addr,
  output logic [W_DATA-1:0]    o_wr_data,
  output logic                 o_csync_done,
  output logic                 o_err
`ifdef FBUF_LOADER_CHECKSUM_EN
  ,
  output logic [W_DATA-1:0]    o_checksum
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, LOAD, DONE} state_t;
  state_t state;
  logic [W_ADDR-1:0] cnt;
  logic [W_ADDR-1:0] len_n;
  logic [W_ADDR-1:0] base_n;
  logic beat;
  logic last;
  assign len_n  = W_ADDR'(i_q_channel) * W_ADDR'(K_WORDS);
  assign base_n = W_ADDR'(i_chn_out) * len_n;
  assign beat   = s_valid & s_ready;
  assign last   = cnt == o_rd_len - W_ADDR'(1);
  // load sequencer: the latched length lives in o_rd_len, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      o_rd_req     <= 1'b0;
      o_rd_base    <= '0;
      o_rd_len     <= '0;
      s_ready      <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_csync_done <= 1'b0;
      o_err        <= 1'b0;
`ifdef FBUF_LOADER_CHECKSUM_EN
      o_checksum   <= '0;
`endif
    end else begin
      o_rd_req <= 1'b0;
      o_wr_en  <= 1'b0;
      if ((i_fb_load_req && state != IDLE) || (!i_csync_run && (state == REQ || state == LOAD)))
        o_err <= 1'b1;
      case (state)
        IDLE: if (i_fb_load_req) begin
          state     <= REQ;
          cnt       <= '0;
          o_rd_req  <= len_n != '0;
          o_rd_base <= base_n;
          o_rd_len  <= len_n;
`ifdef FBUF_LOADER_CHECKSUM_EN
          o_checksum <= '0;
`endif
        end
        REQ: begin
          state        <= o_rd_len == '0 ? DONE : LOAD;
          s_ready      <= o_rd_len != '0;
          o_csync_done <= o_rd_len == '0;
        end
        LOAD: if (beat) begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= cnt;
          o_wr_data <= s_data;
          cnt       <= cnt + W_ADDR'(1);
`ifdef FBUF_LOADER_CHECKSUM_EN
          o_checksum <= o_checksum ^ s_data;
`endif
          if (last) begin
            state        <= DONE;
            s_ready      <= 1'b0;
            o_csync_done <= 1'b1;
          end
        end
        DONE: if (!i_csync_run) begin
          state        <= IDLE;
          o_csync_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fbuf_loader.sv
// tb_fbuf_loader: randomized scoreboard bench for fbuf_loader
module tb_fbuf_loader;
  localparam int WC = 5, WD = 32, WA = 12, K = 9;
  logic clk = 1'b0, rst = 1'b1;
  logic i_fb_load_req = 1'b0, i_csync_run = 1'b1;
  logic [WC-1:0] i_q_channel = '0, i_chn_out = '0;
  logic o_rd_req, s_ready, o_wr_en, o_csync_done, o_err;
  logic [WA-1:0] o_rd_base, o_rd_len, o_wr_addr;
  logic s_valid = 1'b0;
  logic [WD-1:0] s_data = '0, o_wr_data;
`ifdef FBUF_LOADER_CHECKSUM_EN
  logic [WD-1:0] o_checksum;
`endif
  typedef struct {logic [WA-1:0] a; logic [WD-1:0] d; bit last;} wr_t;
  wr_t wr_q[$];
  logic [2*WA-1:0] rd_q[$];
  int vectors = 0, miscompares = 0;
  bit exp_err = 1'b0;
  logic [WD-1:0] exp_ck = '0;

  fbuf_loader dut (
    .clk(clk), .rst(rst), .i_fb_load_req(i_fb_load_req), .i_csync_run(i_csync_run),
    .i_q_channel(i_q_channel), .i_chn_out(i_chn_out), .o_rd_req(o_rd_req),
    .o_rd_base(o_rd_base), .o_rd_len(o_rd_len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_csync_done(o_csync_done), .o_err(o_err)
`ifdef FBUF_LOADER_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string n);
    chk({n, "_ctl"}, 64'({o_rd_req, s_ready, o_wr_en, o_csync_done, o_err, o_rd_base, o_rd_len, o_wr_addr}), 64'(0));
    chk({n, "_wdata"}, 64'(o_wr_data), 64'(0));
`ifdef FBUF_LOADER_CHECKSUM_EN
    chk({n, "_cksum"}, 64'(o_checksum), 64'(0));
`endif
  endtask

  // monitor: every write or read request the DUT presents must match the scoreboard
  always @(negedge clk) if (!rst) begin
    if (o_wr_en) begin
      if (wr_q.size() == 0) chk("unexpected_write", 64'(o_wr_addr), 64'hffff);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 64'(o_wr_addr), 64'(e.a));
        chk("wr_data", 64'(o_wr_data), 64'(e.d));
        chk("done_with_write", 64'(o_csync_done), 64'(e.last));
      end
    end
    if (o_rd_req) begin
      if (rd_q.size() == 0) chk("unexpected_rd_req", 64'(o_rd_len), 64'hffff);
      else begin
        logic [2*WA-1:0] r;
        r = rd_q.pop_front();
        chk("rd_base", 64'(o_rd_base), 64'(r[2*WA-1:WA]));
        chk("rd_len", 64'(o_rd_len), 64'(r[WA-1:0]));
      end
    end
  end

  task automatic finish_load(input int len);
    chk("done_set", 64'(o_csync_done), 64'(1));
    chk("ready_off_done", 64'(s_ready), 64'(0));
    chk("err", 64'(o_err), 64'(exp_err));
    if (len > 0) chk("rd_len_hold", 64'(o_rd_len), 64'(len));
`ifdef FBUF_LOADER_CHECKSUM_EN
    chk("cksum_done", 64'(o_checksum), 64'(exp_ck));
`endif
    repeat ($urandom_range(0, 3)) begin
      s_valid = 1'b1; s_data = $urandom;
      @(posedge clk); #1;
      chk("done_hold", 64'(o_csync_done), 64'(1));
    end
    i_csync_run = 1'b0;
    @(posedge clk); #1;
    i_csync_run = 1'b1;
    chk("done_clear", 64'(o_csync_done), 64'(0));
    @(posedge clk); #1;
    s_valid = 1'b0;
`ifdef FBUF_LOADER_CHECKSUM_EN
    chk("cksum_idle", 64'(o_checksum), 64'(exp_ck));
`endif
  endtask

  // mode 0: continuous valid, 1: toggling, 2: random gaps; returns with beats accepted
  task automatic run_load(input int q, input int chn, input int mode, input bit dup,
                          input bit drop, input int abort_at);
    int len, base, i, cyc;
    bit v, acc;
    logic [WD-1:0] d;
    len = (q * K) % 4096;
    base = (chn * len) % 4096;
    exp_ck = '0;
    if (len > 0) rd_q.push_back({WA'(base), WA'(len)});
    i_q_channel = WC'(q); i_chn_out = WC'(chn); i_fb_load_req = 1'b1;
    @(posedge clk); #1;
    i_fb_load_req = 1'b0;
    chk("done_in_req", 64'(o_csync_done), 64'(0));
    if (len == 0) begin
      @(posedge clk); #1;
      chk("no_ready_zero_len", 64'(s_ready), 64'(0));
      finish_load(0);
      return;
    end
    i = 0; cyc = 0;
    while (i < len && cyc < 8 * len + 16 && (abort_at == 0 || i < abort_at)) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      d = $urandom;
      s_valid = v; s_data = d;
      i_fb_load_req = dup && cyc == 3;
      i_csync_run = !(drop && cyc == 2);
      i_q_channel = WC'($urandom); i_chn_out = WC'($urandom);
      if (dup && cyc == 3) exp_err = 1'b1;
      if (drop && cyc == 2) exp_err = 1'b1;
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      i_fb_load_req = 1'b0; i_csync_run = 1'b1;
      if (v && acc) begin
        wr_q.push_back('{WA'(i), d, i == len - 1});
        exp_ck ^= d;
        i++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    if (abort_at > 0 && i == abort_at) return;
    chk("beats_accepted", 64'(i), 64'(len));
    finish_load(len);
  endtask

  initial begin
    #12;
    check_zero("reset_state");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_load(2, 3, 0, 1'b0, 1'b0, 0);
    run_load(2, 3, 1, 1'b0, 1'b0, 0);
    run_load(0, 5, 2, 1'b0, 1'b0, 0);
    run_load(1, 7, 2, 1'b0, 1'b0, 0);
    run_load(2, 3, 0, 1'b1, 1'b0, 0);
    run_load(2, 3, 0, 1'b0, 1'b0, 5);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero("mid_load_reset");
    chk("pending_writes", 64'(wr_q.size()), 64'(0));
    exp_err = 1'b0;
    @(negedge clk); rst = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_resume", 64'({s_ready, o_csync_done}), 64'(0));
    end
    s_valid = 1'b0;
    run_load(2, 3, 0, 1'b0, 1'b0, 0);
    for (int n = 0; n < 8; n++)
      run_load($urandom_range(0, 31), $urandom_range(0, 31), 2, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("wr_queue_empty", 64'(wr_q.size()), 64'(0));
    chk("rd_queue_empty", 64'(rd_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fbuf_loader.md
FBUF_LOADER -- requirements
Module: fbuf_loader

Interface
REQ-001 Parameters SHALL be: W_CHANNEL, default 5, tiled-channel count width; W_DATA, default 32, weight word width; W_ADDR, default 12, buffer and DRAM word-address width; K_WORDS, default 9, words per input channel per filter group.
REQ-002 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 Ports, in order:
- clk  in  1  clock
- rst  in  1  async active-high reset
- i_fb_load_req  in  1  one-cycle load request from the layer controller
- i_csync_run  in  1  controller is in its CSYNC state
- i_q_channel  in  W_CHANNEL  tiled input-channel count
- i_chn_out  in  W_CHANNEL  output-channel group to load
- o_rd_req  out  1  DRAM read-request pulse
- o_rd_base  out  W_ADDR  read base address
- o_rd_len  out  W_ADDR  read length in words
- s_valid  in  1  weight-stream valid
- s_data  in  W_DATA  weight-stream data
- s_ready  out  1  weight-stream ready
- o_wr_en  out  1  filter-buffer write enable
- o_wr_addr  out  W_ADDR  filter-buffer write address
- o_wr_data  out  W_DATA  filter-buffer write data
- o_csync_done  out  1  load complete; feeds the controller's buffer-manager CSYNC-done input
- o_err  out  1  sticky protocol error
- o_checksum  out  W_DATA  XOR of the loaded words (present only with the configuration macro)

Function
REQ-004 The block SHALL implement four states: IDLE, REQ, LOAD, DONE.
REQ-005 In IDLE, i_fb_load_req=1 SHALL latch the following and move to REQ on the next clock:
- len = i_q_channel*K_WORDS, truncated to W_ADDR
- base = i_chn_out*len, truncated to W_ADDR
REQ-006 If the latched len=0, the block SHALL go from REQ directly to DONE with no o_rd_req and no writes.
REQ-007 In REQ with len>0, the block SHALL pulse o_rd_req for exactly one cycle, with o_rd_base and o_rd_len valid in that cycle, then enter LOAD.
REQ-008 In LOAD, s_ready SHALL be 1; s_ready SHALL be 0 in every other state.
REQ-009 Each beat (s_valid&s_ready) SHALL write to the filter buffer with one-cycle registered latency:
- o_wr_en=1 the cycle after the beat
- o_wr_data = the beat's s_data
- o_wr_addr = the beat index, 0..len-1
REQ-010 The block SHALL enter DONE on the cycle after the beat with index len-1 is accepted; the write for that beat SHALL coincide with the first DONE cycle.
REQ-011 o_csync_done SHALL be 1 exactly while in DONE.
REQ-012 The block SHALL leave DONE for IDLE on the first cycle in which i_csync_run=0.
REQ-013 i_fb_load_req while not in IDLE SHALL be ignored and SHALL set o_err.
REQ-014 i_csync_run=0 while in REQ or LOAD SHALL set o_err; the load SHALL continue to completion.
REQ-015 s_valid outside LOAD SHALL be ignored.
REQ-016 o_rd_base and o_rd_len SHALL hold their last values outside REQ.
REQ-017 The beat counter SHALL reset to 0 on each entry to REQ.

Reset
REQ-018 Asserting rst SHALL asynchronously force, at any time including mid-load:
- state to IDLE
- all outputs to 0: o_rd_req, o_rd_base, o_rd_len, s_ready, o_wr_en, o_wr_addr, o_wr_data, o_csync_done, o_err, o_checksum
- the counter to 0
REQ-019 A load interrupted by reset SHALL NOT resume; a new i_fb_load_req is required.

Configuration
REQ-020 With FBUF_LOADER_CHECKSUM_EN defined:
- o_checksum SHALL clear on entry to REQ
- o_checksum SHALL XOR in each written word in the same cycle as its o_wr_en
- o_checksum SHALL hold its value in DONE and IDLE
REQ-021 Without FBUF_LOADER_CHECKSUM_EN, the o_checksum port and its logic SHALL be absent.

Verification
REQ-022 q_channel=2, chn_out=3, continuous s_valid -> rd_base=54, rd_len=18; 18 writes at addr 0..17; o_csync_done rises in the cycle after the 18th beat.
REQ-023 Same load with s_valid toggling 1/0 -> 18 writes in order, data matches the stream, no duplicates.
REQ-024 q_channel=0 -> no o_rd_req, no writes; DONE two cycles after the request; returns to IDLE when csync_run=0.
REQ-025 Second i_fb_load_req during LOAD -> o_err=1; the original load completes unchanged.
REQ-026 rst pulse after 5 beats -> all outputs 0 immediately; a new request reloads from addr 0.
REQ-027 Checksum build, words 0x1,0x2,0x4 (q_channel=1, K_WORDS=3) -> o_checksum=0x7 in DONE.
